// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Round-robin arbiter that shares the single register-file write port among
//   NUM_REQ writeback sources, plus a per-register pending-write scoreboard
//   used by issue logic for RAW hazard detection on two read addresses.
// Ports
//   clock, ctrl_reset_n            clock (rising edge), async active-low reset
//   req_valid/req_addr/req_data    per-requester write requests (packed slices)
//   req_ready                      one-hot grant (combinational)
//   wb_stall                       suppresses all grants this cycle
//   rsv_valid/rsv_addr/rsv_ready   destination reservation handshake
//   rd_addr_a/b, hazard_a/b        hazard lookup (combinational)
//   out_writeEnable/Reg/Data       registered write command to regfile
module regfile_wb_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                           clock,
  input  logic                           ctrl_reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           wb_stall,
  input  logic                           rsv_valid,
  input  logic [ADDR_WIDTH-1:0]          rsv_addr,
  output logic                           rsv_ready,
  input  logic [ADDR_WIDTH-1:0]          rd_addr_a,
  input  logic [ADDR_WIDTH-1:0]          rd_addr_b,
  output logic                           hazard_a,
  output logic                           hazard_b,
  output logic                           out_writeEnable,
  output logic [ADDR_WIDTH-1:0]          out_writeReg,
  output logic [DATA_WIDTH-1:0]          out_writeData
);

  localparam int NREG  = 2**ADDR_WIDTH;
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [PTR_W-1:0]     LAST    = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      grant_idx;
  logic                  grant_any;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [CNT_WIDTH-1:0]  cnt [NREG];
  logic [NREG-1:0]       rsv_hit;
  logic [NREG-1:0]       wr_hit;

  // Two passes give the rotating priority: first the indices at or above
  // ptr, then wrap around to the lowest valid index below it.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    if (ctrl_reset_n && !wb_stall) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!grant_any && req_valid[i] && (i >= 32'(ptr))) begin
          grant_any = 1'b1;
          grant_idx = PTR_W'(i);
        end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!grant_any && req_valid[i]) begin
          grant_any = 1'b1;
          grant_idx = PTR_W'(i);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant_any && (grant_idx == PTR_W'(i));
      if (req_ready[i]) begin
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign rsv_ready = !((rsv_addr != '0) && (cnt[rsv_addr] == CNT_MAX));

  assign hazard_a = (rd_addr_a != '0) &&
                    ((cnt[rd_addr_a] != '0) ||
                     (out_writeEnable && (out_writeReg == rd_addr_a)));
  assign hazard_b = (rd_addr_b != '0) &&
                    ((cnt[rd_addr_b] != '0) ||
                     (out_writeEnable && (out_writeReg == rd_addr_b)));

  always_comb begin
    rsv_hit = '0;
    wr_hit  = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      rsv_hit[r] = rsv_valid && rsv_ready && (rsv_addr == ADDR_WIDTH'(r));
      wr_hit[r]  = grant_any && (sel_addr == ADDR_WIDTH'(r));
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int unsigned r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      cnt[0] <= '0;
      for (int unsigned r = 1; r < NREG; r++) begin
        // A reserve and a write to the same register cancel out, whatever
        // the count; a lone write only decrements a nonzero count.
        if (rsv_hit[r] && !wr_hit[r])
          cnt[r] <= cnt[r] + 1'b1;
        else if (wr_hit[r] && !rsv_hit[r] && (cnt[r] != '0))
          cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      ptr             <= '0;
      out_writeEnable <= 1'b0;
      out_writeReg    <= '0;
      out_writeData   <= '0;
    end else if (grant_any) begin
      ptr             <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
      out_writeEnable <= (sel_addr != '0);
      out_writeReg    <= sel_addr;
      out_writeData   <= sel_data;
    end else begin
      out_writeEnable <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//   Directed bench for regfile_wb_arbiter. A reference model of the grant
//   pointer and the pending-write counters predicts the combinational outputs
//   each cycle and pushes the expected write command into a queue, which is
//   popped and compared one clock later.
module tb_regfile_wb_arbiter;
  localparam int N    = 3;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int CMAX = 3;

  logic              clock = 1'b0;
  logic              ctrl_reset_n;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              wb_stall;
  logic              rsv_valid;
  logic [AW-1:0]     rsv_addr;
  logic              rsv_ready;
  logic [AW-1:0]     rd_addr_a;
  logic [AW-1:0]     rd_addr_b;
  logic              hazard_a;
  logic              hazard_b;
  logic              out_writeEnable;
  logic [AW-1:0]     out_writeReg;
  logic [DW-1:0]     out_writeData;

  logic [AW-1:0]     a_v [N];
  logic [DW-1:0]     d_v [N];

  always #5 clock = ~clock;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = a_v[i];
      req_data[i*DW +: DW] = d_v[i];
    end
  end

  regfile_wb_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(2)
  ) dut (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .wb_stall(wb_stall),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .hazard_a(hazard_a), .hazard_b(hazard_b),
    .out_writeEnable(out_writeEnable), .out_writeReg(out_writeReg),
    .out_writeData(out_writeData)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] rg;
    logic [DW-1:0] dt;
  } wr_t;

  wr_t           q[$];
  int            ptr_m;
  int            cnt_m [32];
  logic          we_m;
  logic [AW-1:0] reg_m;
  logic [DW-1:0] data_m;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_hazard(input logic [AW-1:0] a);
    return (a != 0) && ((cnt_m[a] != 0) || (we_m && reg_m == a));
  endfunction

  task automatic reset_model();
    ptr_m = 0;
    for (int r = 0; r < 32; r++) cnt_m[r] = 0;
    we_m = 1'b0; reg_m = '0; data_m = '0;
    q.delete();
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = v;
    a_v[i] = a;
    d_v[i] = d;
  endtask

  // One clock: check combinational outputs against the model, predict the
  // registered write command, advance the model, then check after the edge.
  task automatic cycle(input string tag);
    logic [N-1:0] g;
    int           gi;
    logic         rr;
    wr_t          nxt;
    wr_t          got;
    int           r_rsv;
    int           r_wr;
    #1;
    g  = '0;
    gi = -1;
    if (!wb_stall)
      for (int k = 0; k < N; k++) begin
        int i;
        i = (ptr_m + k) % N;
        if (gi < 0 && req_valid[i]) gi = i;
      end
    if (gi >= 0) g[gi] = 1'b1;
    rr = !(rsv_addr != 0 && cnt_m[rsv_addr] == CMAX);
    check({tag, " req_ready"}, 64'(req_ready), 64'(g));
    check({tag, " rsv_ready"}, 64'(rsv_ready), 64'(rr));
    check({tag, " hazard_a"}, 64'(hazard_a), 64'(exp_hazard(rd_addr_a)));
    check({tag, " hazard_b"}, 64'(hazard_b), 64'(exp_hazard(rd_addr_b)));
    if (gi >= 0) begin
      nxt.we = (a_v[gi] != 0);
      nxt.rg = a_v[gi];
      nxt.dt = d_v[gi];
      ptr_m  = (gi + 1) % N;
    end else begin
      nxt.we = 1'b0;
      nxt.rg = reg_m;
      nxt.dt = data_m;
    end
    q.push_back(nxt);
    r_rsv = (rsv_valid && rr && rsv_addr != 0) ? int'(rsv_addr) : -1;
    r_wr  = (gi >= 0 && a_v[gi] != 0) ? int'(a_v[gi]) : -1;
    if (!(r_rsv >= 0 && r_rsv == r_wr)) begin
      if (r_rsv >= 0) cnt_m[r_rsv]++;
      if (r_wr >= 0 && cnt_m[r_wr] > 0) cnt_m[r_wr]--;
    end
    @(posedge clock);
    #1;
    got = q.pop_front();
    check({tag, " out_writeEnable"}, 64'(out_writeEnable), 64'(got.we));
    check({tag, " out_writeReg"}, 64'(out_writeReg), 64'(got.rg));
    check({tag, " out_writeData"}, 64'(out_writeData), 64'(got.dt));
    we_m   = got.we;
    reg_m  = got.rg;
    data_m = got.dt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_model();
    ctrl_reset_n = 1'b0;
    wb_stall  = 1'b0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    rd_addr_a = 5'd9;
    rd_addr_b = 5'd4;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 1), 32'hdead_0000 + DW'(i));

    // In reset: no grants even with every requester valid, outputs cleared.
    @(posedge clock);
    #1;
    check("rst req_ready", 64'(req_ready), 64'(0));
    check("rst out_writeEnable", 64'(out_writeEnable), 64'(0));
    check("rst out_writeReg", 64'(out_writeReg), 64'(0));
    check("rst out_writeData", 64'(out_writeData), 64'(0));
    check("rst hazard_a", 64'(hazard_a), 64'(0));
    for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0);
    #3;
    ctrl_reset_n = 1'b1;

    cycle("idle0");
    cycle("idle1");

    // Round robin over three held requesters: grants 0,1,2,0.
    set_req(0, 1'b1, 5'd5, 32'h1111_0005);
    set_req(1, 1'b1, 5'd6, 32'h2222_0006);
    set_req(2, 1'b1, 5'd7, 32'h3333_0007);
    cycle("rr0");
    check("rr0 writeReg is 5", 64'(out_writeReg), 64'(5));
    cycle("rr1");
    check("rr1 writeReg is 6", 64'(out_writeReg), 64'(6));
    cycle("rr2");
    check("rr2 writeReg is 7", 64'(out_writeReg), 64'(7));
    cycle("rr3");
    check("rr3 writeReg is 5", 64'(out_writeReg), 64'(5));
    req_valid = '0;

    // Reserve r9, see the hazard, write it, observe the in-flight cycle.
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    cycle("rsv9");
    rsv_valid = 1'b0;
    cycle("haz9_pending");
    set_req(0, 1'b1, 5'd9, 32'h0909_0909);
    cycle("wr9");
    req_valid = '0;
    check("inflight9 hazard_a", 64'(hazard_a), 64'(1));
    cycle("inflight9");
    cycle("clear9");
    check("clear9 hazard_a", 64'(hazard_a), 64'(0));

    // Saturate r4, then cancel a reserve against a write.
    rsv_valid = 1'b1; rsv_addr = 5'd4;
    cycle("rsv4_a");
    cycle("rsv4_b");
    cycle("rsv4_c");
    cycle("rsv4_full");
    check("rsv4_full rejected", 64'(rsv_ready), 64'(0));
    rsv_valid = 1'b0;
    set_req(1, 1'b1, 5'd4, 32'h0404_0001);
    req_valid = 3'b010;
    cycle("wr4");
    rsv_valid = 1'b1;
    set_req(2, 1'b1, 5'd4, 32'h0404_0002);
    req_valid = 3'b100;
    cycle("rsv_wr4_same");
    req_valid = '0;
    cycle("rsv4_refill");
    rsv_valid = 1'b0;
    cycle("rsv4_check_full");
    check("rsv4 full again", 64'(rsv_ready), 64'(0));

    // Write to r0 is granted but never reaches the regfile.
    set_req(0, 1'b1, 5'd0, 32'hffff_ffff);
    req_valid = 3'b001;
    rd_addr_a = 5'd0;
    cycle("wr0");
    check("wr0 no write", 64'(out_writeEnable), 64'(0));
    req_valid = '0;

    // Stall blocks a grant; then a grant moves the pointer off zero.
    wb_stall = 1'b1;
    set_req(1, 1'b1, 5'd6, 32'h6666_6666);
    req_valid = 3'b010;
    cycle("stall");
    wb_stall = 1'b0;
    cycle("unstall");

    // Asynchronous reset mid-stream, then the pointer restarts at zero.
    set_req(0, 1'b1, 5'd10, 32'haaaa_000a);
    set_req(2, 1'b1, 5'd12, 32'hcccc_000c);
    req_valid = 3'b111;
    rd_addr_a = 5'd6;
    #2;
    ctrl_reset_n = 1'b0;
    #1;
    check("midrst req_ready", 64'(req_ready), 64'(0));
    check("midrst out_writeEnable", 64'(out_writeEnable), 64'(0));
    check("midrst out_writeReg", 64'(out_writeReg), 64'(0));
    check("midrst out_writeData", 64'(out_writeData), 64'(0));
    check("midrst hazard_a", 64'(hazard_a), 64'(0));
    check("midrst hazard_b", 64'(hazard_b), 64'(0));
    reset_model();
    #2;
    ctrl_reset_n = 1'b1;
    cycle("postrst");
    check("postrst writeReg is 10", 64'(out_writeReg), 64'(10));
    req_valid = '0;
    cycle("drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
